// File: rtl/fir_tdm_filter.sv
// Signed FIR filter with one shared multiply-accumulate unit, a circular sample buffer
// and a coefficient bank that can be rewritten at run time.
module fir_tdm_filter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned COEFF_W = 16,
    parameter int unsigned TAPS    = 16,
    localparam int unsigned ACC_W  = WIDTH + COEFF_W + $clog2(TAPS),
    localparam int unsigned AW     = $clog2(TAPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    input  logic               coef_we,
    input  logic [AW-1:0]      coef_addr,
    input  logic [COEFF_W-1:0] coef_wdata,
    input  logic               clear,
    output logic               busy
);

    localparam int unsigned PW = WIDTH + COEFF_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t                    state;
    logic signed [WIDTH-1:0]   smp  [TAPS];
    logic signed [COEFF_W-1:0] coef [TAPS];
    logic [AW-1:0]             wp;
    logic [AW-1:0]             tap;
    logic signed [ACC_W-1:0]   acc;
    logic [AW-1:0]             rd_idx_c;
    logic signed [PW-1:0]      prod_c;
    logic signed [ACC_W-1:0]   sum_c;

    assign in_ready = (state == S_IDLE) && !clear;
    assign busy     = (state != S_IDLE);

    // Newest sample sits at wp; older samples are found walking backwards with wrap.
    always_comb begin
        rd_idx_c = '0;
        if (tap <= wp) begin
            rd_idx_c = wp - tap;
        end else begin
            rd_idx_c = AW'((AW+1)'(TAPS) + {1'b0, wp} - {1'b0, tap});
        end
    end

    always_comb begin
        prod_c = PW'(coef[tap]) * PW'(smp[rd_idx_c]);
        sum_c  = acc + ACC_W'(prod_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
            wp        <= '0;
            tap       <= '0;
            for (int i = 0; i < TAPS; i++) begin
                smp[i]  <= '0;
                coef[i] <= COEFF_W'(i + 1);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (coef_we && (32'(coef_addr) < TAPS)) begin
                        coef[coef_addr] <= coef_wdata;
                    end
                    // Clear takes priority over an offered sample.
                    if (clear) begin
                        wp <= '0;
                        for (int i = 0; i < TAPS; i++) begin
                            smp[i] <= '0;
                        end
                    end else if (in_valid) begin
                        smp[wp] <= in_data;
                        tap     <= '0;
                        acc     <= '0;
                        state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= sum_c;
                    tap <= tap + AW'(1);
                    if (tap == AW'(TAPS - 1)) begin
                        out_data  <= sum_c;
                        out_valid <= 1'b1;
                        wp        <= (wp == AW'(TAPS - 1)) ? '0 : wp + AW'(1);
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tdm_filter.sv
// Testbench for fir_tdm_filter: directed and random samples checked against a
// convolution model built from a sample-history queue and a coefficient array.
module tb_fir_tdm_filter;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned COEFF_W = 16;
    localparam int unsigned TAPS    = 16;
    localparam int unsigned AW      = 4;
    localparam int unsigned ACC_W   = 36;

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [ACC_W-1:0]          out_data;
    logic                      coef_we;
    logic [AW-1:0]             coef_addr;
    logic [COEFF_W-1:0]        coef_wdata;
    logic                      clear;
    logic                      busy;

    int tests;
    int fails;

    longint coef_m [TAPS];
    longint hist [$];

    fir_tdm_filter #(.WIDTH(WIDTH), .COEFF_W(COEFF_W), .TAPS(TAPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .clear      (clear),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: y = sum c[k] * x[n-k], missing history counts as zero.
    function automatic longint model_y();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) begin
            if (k < hist.size()) s += coef_m[k] * hist[k];
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) coef_m[k] = longint'(k + 1);
        hist.delete();
    endtask

    task automatic model_push(input longint x);
        hist.push_front(x);
        if (hist.size() > TAPS) void'(hist.pop_back());
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic signed [COEFF_W-1:0] d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        @(posedge clk);
        coef_m[a] = longint'(d);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Offers one sample (optionally with a same-edge coef write), returns result and latency.
    task automatic run_sample(input logic signed [WIDTH-1:0] x, input bit we,
                              input logic [AW-1:0] a, input logic signed [COEFF_W-1:0] d,
                              output logic signed [ACC_W-1:0] y, output int lat);
        int w;
        @(negedge clk);
        in_data = x; in_valid = 1'b1;
        coef_we = we; coef_addr = a; coef_wdata = d;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            in_valid = 1'b0; coef_we = 1'b0;
            y = 'x; lat = -1;
            return;
        end
        @(posedge clk);
        if (we) coef_m[a] = longint'(d);
        model_push(longint'(x));
        @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        y = out_data;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++;
        if (out_data !== '0) begin fails++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_impulse();
        logic signed [ACC_W-1:0] y;
        int lat;
        for (int i = 0; i < 18; i++) begin
            run_sample((i == 0) ? 16'sd1 : 16'sd0, 1'b0, '0, '0, y, lat);
            tests++;
            if (lat != TAPS) begin fails++; $display("FAIL impulse_latency[%0d] got %0d exp %0d", i, lat, TAPS); end
            tests++;
            if (y !== ACC_W'((i < 16) ? i + 1 : 0)) begin
                fails++; $display("FAIL impulse[%0d] got %0d exp %0d", i, y, (i < 16) ? i + 1 : 0);
            end
        end
    endtask

    task automatic test_step();
        logic signed [ACC_W-1:0] y;
        int lat;
        longint e;
        for (int i = 0; i < 18; i++) begin
            run_sample(16'sd1, 1'b0, '0, '0, y, lat);
            e = model_y();
            tests++;
            if (y !== ACC_W'(e)) begin fails++; $display("FAIL step[%0d] got %0d exp %0d", i, y, e); end
        end
        tests++;
        if (y !== ACC_W'(136)) begin fails++; $display("FAIL step_final got %0d exp 136", y); end
    endtask

    task automatic test_backpressure();
        logic signed [WIDTH-1:0] x2;
        logic [ACC_W-1:0] held;
        longint e;
        int w;
        @(negedge clk);
        in_data = 16'($urandom); in_valid = 1'b1;
        @(posedge clk);
        model_push(longint'($signed(in_data)));
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        e = model_y();
        held = out_data;
        tests++;
        if (held !== ACC_W'(e)) begin fails++; $display("FAIL bp_result got %0d exp %0d", $signed(held), e); end
        x2 = 16'($urandom);
        in_data = x2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_data !== ACC_W'(e) || in_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold[%0d] got v=%b d=%0d rdy=%b busy=%b exp v=1 d=%0d rdy=0 busy=1",
                         i, out_valid, $signed(out_data), in_ready, busy, e);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
        @(posedge clk);
        model_push(longint'(x2));
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL bp_next_accept got busy=%b exp 1", busy); end
        w = 0;
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        e = model_y();
        tests++;
        if (out_data !== ACC_W'(e)) begin fails++; $display("FAIL bp_next got %0d exp %0d", $signed(out_data), e); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_coef_during_mac();
        logic signed [ACC_W-1:0] y;
        int lat;
        int w;
        longint e;
        @(negedge clk);
        in_data = 16'($urandom); in_valid = 1'b1;
        @(posedge clk);
        model_push(longint'($signed(in_data)));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        coef_we = 1'b1; coef_addr = '0; coef_wdata = 16'sd100;
        @(negedge clk);
        coef_we = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        e = model_y();
        tests++;
        if (out_data !== ACC_W'(e)) begin fails++; $display("FAIL coef_mid_mac got %0d exp %0d", $signed(out_data), e); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        run_sample(16'($urandom), 1'b0, '0, '0, y, lat);
        e = model_y();
        tests++;
        if (y !== ACC_W'(e)) begin fails++; $display("FAIL coef_mid_mac_next got %0d exp %0d", y, e); end
    endtask

    task automatic test_clear();
        logic signed [ACC_W-1:0] y;
        int lat;
        longint e;
        run_sample(16'sd5, 1'b0, '0, '0, y, lat);
        e = model_y();
        tests++;
        if (y !== ACC_W'(e)) begin fails++; $display("FAIL clear_pre5 got %0d exp %0d", y, e); end
        run_sample(16'sd7, 1'b0, '0, '0, y, lat);
        e = model_y();
        tests++;
        if (y !== ACC_W'(e)) begin fails++; $display("FAIL clear_pre7 got %0d exp %0d", y, e); end
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'sd9;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL clear_in_ready got %b exp 0", in_ready); end
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        hist.delete();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL clear_wins got busy=%b exp 0", busy); end
        for (int i = 0; i < 4; i++) begin
            run_sample((i == 0) ? 16'sd1 : 16'sd0, 1'b0, '0, '0, y, lat);
            tests++;
            if (y !== ACC_W'(i + 1)) begin fails++; $display("FAIL clear_impulse[%0d] got %0d exp %0d", i, y, i + 1); end
        end
    endtask

    task automatic test_random();
        logic signed [ACC_W-1:0] y;
        int lat;
        longint e;
        bit we;
        for (int i = 0; i < 40; i++) begin
            we = ($urandom_range(0, 3) == 0);
            run_sample(16'($urandom), we, 4'($urandom), 16'($urandom), y, lat);
            e = model_y();
            tests++;
            if (y !== ACC_W'(e) || lat != TAPS) begin
                fails++; $display("FAIL random[%0d] got %0d lat %0d exp %0d lat %0d", i, y, lat, e, TAPS);
            end
        end
    endtask

    task automatic test_neg_extreme();
        logic signed [ACC_W-1:0] y;
        int lat;
        longint e;
        for (int k = 0; k < TAPS; k++) write_coef(AW'(k), -16'sd32768);
        for (int i = 0; i < 16; i++) begin
            run_sample(-16'sd32768, 1'b0, '0, '0, y, lat);
            e = model_y();
            tests++;
            if (y !== ACC_W'(e)) begin fails++; $display("FAIL neg_extreme[%0d] got %0d exp %0d", i, y, e); end
        end
        tests++;
        if (y !== 36'sd17179869184) begin fails++; $display("FAIL neg_extreme_final got %0d exp 17179869184", y); end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [ACC_W-1:0] y;
        int lat;
        write_coef(4'd3, 16'sd77);
        @(negedge clk);
        in_data = 16'sd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_mac got v=%b busy=%b d=%0d rdy=%b exp v=0 busy=0 d=0 rdy=1",
                     out_valid, busy, out_data, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            run_sample((i == 0) ? 16'sd1 : 16'sd0, 1'b0, '0, '0, y, lat);
            tests++;
            if (y !== ACC_W'(i + 1)) begin fails++; $display("FAIL rst_restore[%0d] got %0d exp %0d", i, y, i + 1); end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_impulse();
        test_step();
        test_backpressure();
        do_reset();
        test_coef_during_mac();
        test_clear();
        test_random();
        test_neg_extreme();
        test_reset_mid_mac();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
